// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters plus one registered
// decode stage producing syncs, data-enable, coordinates and strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iEn,
    output logic             oHSync,
    output logic             oVSync,
    output logic             oDE,
    output logic [CNT_W-1:0] oX,
    output logic [CNT_W-1:0] oY,
    output logic             oLineStart,
    output logic             oFrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_N = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_N = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             h_wrap;
    logic             v_wrap;

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (iEn) begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= v_wrap ? '0 : vcnt + ONE;
            end else begin
                hcnt <= hcnt + ONE;
            end
        end
    end

    logic de_d;
    logic hs_on;
    logic vs_on;
    logic line_d;
    logic frame_d;

    // VSYNC depends only on vcnt, so its edges fall on hcnt=0 naturally
    always_comb begin
        de_d    = (hcnt < H_ACT_N) && (vcnt < V_ACT_N);
        hs_on   = (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs_on   = (vcnt >= VS_BEG) && (vcnt < VS_END);
        line_d  = (hcnt == '0);
        frame_d = (hcnt == '0) && (vcnt == '0);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oX          <= '0;
            oY          <= '0;
            oDE         <= 1'b0;
            oHSync      <= ~HS_POL;
            oVSync      <= ~VS_POL;
            oLineStart  <= 1'b0;
            oFrameStart <= 1'b0;
        end else if (iEn) begin
            oX          <= hcnt;
            oY          <= vcnt;
            oDE         <= de_d;
            oHSync      <= hs_on ? HS_POL : ~HS_POL;
            oVSync      <= vs_on ? VS_POL : ~VS_POL;
            oLineStart  <= line_d;
            oFrameStart <= frame_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small 14x8 raster, two polarities side by side,
// directed table, full-frame counts, random iEn, gating and mid-frame reset.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;

    logic       hs1, vs1, de1, ls1, fs1;
    logic [7:0] x1, y1;
    logic       hs0, vs0, de0, ls0, fs0;
    logic [7:0] x0, y0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(8)
    ) dut_p (
        .iClk(clk), .iRst_n(rst_n), .iEn(en),
        .oHSync(hs1), .oVSync(vs1), .oDE(de1),
        .oX(x1), .oY(y1),
        .oLineStart(ls1), .oFrameStart(fs1)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(8)
    ) dut_n (
        .iClk(clk), .iRst_n(rst_n), .iEn(en),
        .oHSync(hs0), .oVSync(vs0), .oDE(de0),
        .oX(x0), .oY(y0),
        .oLineStart(ls0), .oFrameStart(fs0)
    );

    int errors = 0;
    int checks = 0;
    int k = 0;

    typedef struct {
        logic en;
        int   x;
        int   y;
        logic de;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    vec_t tbl[16];

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic e);
        en = e;
        @(negedge clk);
        if (e && rst_n) k++;
    endtask

    function automatic int pos_of(input int kk);
        return (kk - 1) % 112;
    endfunction

    // Expected outputs from the count of enabled ticks since reset
    task automatic check_model(input string tag);
        int p, ex, ey;
        logic ede, ehs, evs, els, efs;
        if (k == 0) begin
            ex = 0; ey = 0;
            ede = 0; ehs = 0; evs = 0; els = 0; efs = 0;
        end else begin
            p   = pos_of(k);
            ex  = p % 14;
            ey  = p / 14;
            ede = (ex < 8) && (ey < 4);
            ehs = (ex >= 10) && (ex < 13);
            evs = (ey >= 5) && (ey < 7);
            els = (ex == 0);
            efs = (p == 0);
        end
        cmp({tag, ".x"}, x1, ex);
        cmp({tag, ".y"}, y1, ey);
        cmp({tag, ".de"}, de1, ede);
        cmp({tag, ".hs"}, hs1, ehs);
        cmp({tag, ".vs"}, vs1, evs);
        cmp({tag, ".ls"}, ls1, els);
        cmp({tag, ".fs"}, fs1, efs);
        cmp({tag, ".hs_neg"}, hs0, !ehs);
        cmp({tag, ".vs_neg"}, vs0, !evs);
        cmp({tag, ".x_neg"}, x0, ex);
        cmp({tag, ".y_neg"}, y0, ey);
        cmp({tag, ".de_neg"}, de0, ede);
        cmp({tag, ".fs_neg"}, fs0, efs);
    endtask

    initial begin
        int vs_n, fs_n;
        bit found;

        tbl[0]  = '{1'b1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b1,  1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1,  2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1,  3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1,  4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1,  5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1,  6, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1,  7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1,  8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1,  9, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 11, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 12, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 13, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1,  0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b1,  1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset values, including a clock edge with iEn high under reset
        repeat (2) @(negedge clk);
        check_model("rst");
        tick(1'b1);
        check_model("rst_en");

        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].en);
            cmp($sformatf("tbl%0d.x", i), x1, tbl[i].x);
            cmp($sformatf("tbl%0d.y", i), y1, tbl[i].y);
            cmp($sformatf("tbl%0d.de", i), de1, tbl[i].de);
            cmp($sformatf("tbl%0d.hs", i), hs1, tbl[i].hs);
            cmp($sformatf("tbl%0d.vs", i), vs1, tbl[i].vs);
            cmp($sformatf("tbl%0d.ls", i), ls1, tbl[i].ls);
            cmp($sformatf("tbl%0d.fs", i), fs1, tbl[i].fs);
            cmp($sformatf("tbl%0d.hs_neg", i), hs0, !tbl[i].hs);
            cmp($sformatf("tbl%0d.vs_neg", i), vs0, !tbl[i].vs);
        end

        // one whole frame with iEn high
        vs_n = 0;
        fs_n = 0;
        for (int i = 0; i < 112; i++) begin
            tick(1'b1);
            check_model("frame");
            if (vs1) vs_n++;
            if (fs1) fs_n++;
        end
        cmp("frame.vs_ticks", vs_n, 28);
        cmp("frame.fs_count", fs_n, 1);

        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 3) != 0);
            check_model("rand");
        end

        // iEn gating around the line wrap: enabled ticks show 13 then 0
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (pos_of(k) % 14 == 12) found = 1;
            else tick(1'b1);
        end
        if (!found) begin
            errors++;
            checks++;
            $display("FAIL gate_align: got none expected x=12");
        end
        tick(1'b1); check_model("gate13");
        tick(1'b1); check_model("gate0");
        tick(1'b0); check_model("gate_hold1");
        cmp("gate_hold1.ls_held", ls1, 1);
        tick(1'b0); check_model("gate_hold2");
        cmp("gate_hold2.x_held", x1, 0);
        tick(1'b1); check_model("gate1");
        cmp("gate1.ls_clear", ls1, 0);

        // mid-frame reset inside the VSYNC pulse
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (pos_of(k) == 5 * 14 + 3) found = 1;
            else tick(1'b1);
        end
        if (!found) begin
            errors++;
            checks++;
            $display("FAIL rst_align: got none expected y=5");
        end
        cmp("pre_rst.vs", vs1, 1);
        rst_n = 1'b0;
        #1;
        k = 0;
        check_model("async_rst");
        @(negedge clk);
        check_model("rst_pulse");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            check_model("restart");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA output path: free-running horizontal and vertical counters with configurable active/porch/sync widths, producing registered HSYNC, VSYNC, data-enable, pixel coordinates and line/frame start strobes. It sits between the pixel clock and the memory-read/pixel-output logic, which uses oX/oY to address frame memory and oDE to gate pixel data. Defaults give 1920x1080 timing (2200x1125 total).

## Interface

Parameters:
- H_ACTIVE, 1920, visible pixels per line
- H_FP, 88, horizontal front porch, in pixels
- H_SYNC, 44, HSYNC pulse width, in pixels
- H_BP, 148, horizontal back porch, in pixels
- V_ACTIVE, 1080, visible lines per frame
- V_FP, 4, vertical front porch, in lines
- V_SYNC, 5, VSYNC pulse width, in lines
- V_BP, 36, vertical back porch, in lines
- HS_POL, 1, HSYNC active level (1 = active-high)
- VS_POL, 1, VSYNC active level
- CNT_W, 16, counter and coordinate width

Ports:
- iClk  in  1  pixel clock; all logic is on its rising edge
- iRst_n  in  1  asynchronous active-low reset
- iEn  in  1  pixel-tick enable; state advances only on cycles where it is 1
- oHSync  out  1  horizontal sync at HS_POL level during the sync pulse
- oVSync  out  1  vertical sync at VS_POL level during the sync pulse
- oDE  out  1  data enable, 1 inside the active region
- oX  out  CNT_W  horizontal position, 0..H_TOTAL-1
- oY  out  CNT_W  vertical position, 0..V_TOTAL-1
- oLineStart  out  1  one-tick strobe at X=0
- oFrameStart  out  1  one-tick strobe at X=0, Y=0

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- CNT_W must hold H_TOTAL-1 and V_TOTAL-1. All comparisons use the full CNT_W width.
- Stage 1, counters hcnt and vcnt:
  - When iEn=1, hcnt increments.
  - At hcnt=H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - At vcnt=V_TOTAL-1 together with the hcnt wrap, vcnt wraps to 0.
  - When iEn=0, both counters hold.
- Stage 2, output register: loaded on every iEn=1 cycle with the decode of the current (hcnt, vcnt):
  - oX=hcnt, oY=vcnt. These are raw values, also valid during blanking.
  - oDE = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE).
  - HSYNC is active when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; oHSync = active ? HS_POL : ~HS_POL.
  - VSYNC is active when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, with the same polarity rule using VS_POL. Transitions are line-aligned, at hcnt=0.
  - oLineStart = (hcnt==0).
  - oFrameStart = (hcnt==0 && vcnt==0).
- When iEn=0, every stage-2 output holds its value, including the strobes. A strobe therefore lasts exactly one enabled tick, not one clock.

## Timing

- Reset (iRst_n=0), asynchronous, takes effect immediately:
  - hcnt=vcnt=0.
  - oX=oY=0, oDE=0, oLineStart=0, oFrameStart=0.
  - oHSync=~HS_POL, oVSync=~VS_POL (inactive).
- First enabled tick after reset release:
  - Outputs show position (0,0): oDE=1, oLineStart=1, oFrameStart=1.
  - Counters become (1,0).
- Latency: outputs describe the counter state of the previous enabled tick, a fixed one-tick pipeline. oX, oY, oDE, syncs and strobes are mutually aligned.
- Period: H_TOTAL enabled ticks per line; H_TOTAL*V_TOTAL enabled ticks per frame.
- Reset asserted mid-frame: all state returns to reset values at once. The next frame restarts at (0,0) with no partial sync pulse carried over.
- iEn held high continuously gives one pixel per clock. Toggling iEn stretches the timing uniformly and never skips or repeats a position.

## Test plan

Directed tests use small parameters: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), CNT_W=8, iEn=1 unless stated.

- Reset values, then release:
  - While iRst_n=0: oHSync=0, oVSync=0, oDE=0, oX=oY=0, no strobes.
  - First tick after release: oX=0, oY=0, oDE=1, oLineStart=1, oFrameStart=1.
- One full line:
  - oDE=1 for oX 0..7 and 0 for oX 8..13.
  - oHSync=1 only for oX 10..12.
  - After oX=13, the next tick gives oX=0, oY=1, oLineStart=1, oFrameStart=0.
- Full frame of 112 ticks:
  - oVSync=1 exactly for oY 5..6, i.e. 28 ticks, starting at oX=0.
  - oDE=0 for all of oY 4..7.
  - oFrameStart recurs every 112 ticks.
- Polarity, with HS_POL=0 and VS_POL=0:
  - Syncs idle at 1 and pulse to 0 at the same positions as above.
  - At reset, oHSync=oVSync=1.
- iEn gating:
  - Drive iEn=1 0 0 1 around the oX=13 to 0 wrap.
  - Outputs hold for 2 clocks; oLineStart stays high for those held cycles and clears on the next enabled tick.
  - No position is skipped or repeated.
- Mid-frame reset:
  - Pulse iRst_n=0 for 1 cycle at oY=5 (inside VSYNC).
  - oVSync drops to 0 asynchronously and the counters restart.
  - The next frame begins at (0,0) with oFrameStart=1.
